mux_rr_arbiter: RTL

//  Upstream control stage for the 8-channel 32b data mux: round-robin arbiter that drives the mux selector.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_rr_arbiter_rr_pick.sv | 36 +++
 rtl/mux_rr_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the 8-channel 32b data mux and its round-robin arbiter.
package mux_pkg;

    localparam int NUM_CH     = 8;
    localparam int SEL_W      = 3;
    localparam int DATA_WIDTH = 32;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping past the top channel.
module rr_pick
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              ptr,
    output logic              found,
    output sel_t              idx
);

    sel_t              w_pos [NUM_CH];
    logic [NUM_CH-1:0] w_rot;
    sel_t              w_off;

    // Rotate the request vector so that bit 0 corresponds to ptr; sel_t addition wraps 7->0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign w_pos[gi] = ptr + sel_t'(gi);
            assign w_rot[gi] = req[w_pos[gi]];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = sel_t'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = ptr + w_off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 8-channel mux selector; grants are held until done_i.
// Optional grant timeout is compiled in when MUX_ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              done_i,
    output sel_t              selector_o,
    output logic [NUM_CH-1:0] grant_o,
    output logic              valid_o,
    output logic              timeout_o
);

    arb_state_e        r_state, w_state_next;
    sel_t              r_ptr, w_ptr_next;
    sel_t              r_sel, w_sel_next;
    logic [NUM_CH-1:0] r_grant, w_grant_next;
    logic              r_valid, w_valid_next;
    logic              r_timeout, w_timeout_next;

    logic              w_found;
    sel_t              w_idx;
    sel_t              w_pick_ptr;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_release;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !done_i;
    assign w_release = done_i || w_expired;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYC > 0);
    assign w_release    = done_i;
`endif

    // While granting, the search starts just past the current channel so it ranks last.
    assign w_pick_ptr = (r_state == ARB_GRANT) ? (r_sel + sel_t'(1)) : r_ptr;
    assign w_onehot   = {{(NUM_CH-1){1'b0}}, 1'b1} << w_idx;

    rr_pick u_rr_pick (
        .req   (req_i),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_sel_next     = r_sel;
        w_grant_next   = r_grant;
        w_valid_next   = r_valid;
        w_timeout_next = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        w_cnt_next     = r_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_next = ARB_GRANT;
                    w_sel_next   = w_idx;
                    w_grant_next = w_onehot;
                    w_valid_next = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                    w_cnt_next   = '0;
`endif
                end
            end
            ARB_GRANT: begin
                if (w_release) begin
                    w_ptr_next = w_pick_ptr;
`ifdef MUX_ARB_TIMEOUT_EN
                    w_timeout_next = w_expired;
                    w_cnt_next     = '0;
`endif
                    if (w_found) begin
                        w_sel_next   = w_idx;
                        w_grant_next = w_onehot;
                        w_valid_next = 1'b1;
                    end else begin
                        w_state_next = ARB_IDLE;
                        w_grant_next = '0;
                        w_valid_next = 1'b0;
                    end
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    w_cnt_next = r_cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
                w_grant_next = '0;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_sel     <= w_sel_next;
            r_grant   <= w_grant_next;
            r_valid   <= w_valid_next;
            r_timeout <= w_timeout_next;
`ifdef MUX_ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_next;
`endif
        end
    end

    assign selector_o = r_sel;
    assign grant_o    = r_grant;
    assign valid_o    = r_valid;
    assign timeout_o  = r_timeout;

endmodule
